pipe_stall_ctrl: RTL
====================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter STAGES, default 4: number of pipeline registers/units (index 0 = fetch side); legal range 2..8.
REQ-002 Parameter PC_W, default 64: redirect address width.
REQ-003 Parameter BR_STAGE, default 2: unit index that resolves redirects; legal range 1..STAGES-1.
REQ-004 Parameter CNT_W, default 8: stall counter width.
REQ-005 Parameter WD_LIMIT, default 200: stall cycle count that raises the watchdog; must be below 2^CNT_W.
REQ-006 clk  in  1  clock; the block has one clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 blk_req_i  in  STAGES  unit i requests a pipeline freeze.
REQ-009 blk_done_i  in  STAGES  unit i finished its blocking operation (ready).
REQ-010 redirect_i  in  1  redirect raised by unit BR_STAGE.
REQ-011 redirect_pc_i  in  PC_W  redirect target.
REQ-012 trap_i  in  1  trap flush request.
REQ-013 trap_pc_i  in  PC_W  trap vector.
REQ-014 stage_ctrl_o  out  2*STAGES  per-register control, field i at bits [2i+1:2i]; 00 RUN, 01 BLOCK, 10 BUBBLE.
REQ-015 pc_ctrl_o  out  2  00 RUN, 01 BLOCK, 10 LOAD.
REQ-016 pc_new_o  out  PC_W  address loaded when pc_ctrl_o = LOAD.
REQ-017 unit_en_o  out  STAGES  1 = unit i may advance its internal operation.
REQ-018 stall_cnt_o  out  CNT_W  cycles spent in the current stall.
REQ-019 wd_o  out  1  stall watchdog flag.

Function
REQ-020 The FSM SHALL have states RUN, STALL, REDIR and REDIR_WAIT, registered on clk; all other outputs are combinational from state and inputs.
REQ-021 In RUN with any blk_req_i bit set, owner SHALL be the highest set index; all stage fields BLOCK, pc BLOCK, unit_en_o only owner bit (plus bit 0 if owner is 0); owner latched; next state STALL.
REQ-022 In RUN with no blk_req_i and redirect_i = 1: pc LOAD with pc_new_o = redirect_pc_i, fields 0..BR_STAGE-1 BUBBLE, remaining fields RUN, unit_en_o all ones; next state REDIR.
REQ-023 blk_req_i SHALL take priority over a simultaneous redirect_i; the redirecting unit holds redirect_i until accepted.
REQ-024 In RUN with no requests: all fields RUN, pc RUN, unit_en_o all ones.
REQ-025 In STALL: all fields and pc BLOCK, unit_en_o only latched owner bit; when blk_done_i[owner] = 1, next state RUN (outputs that cycle still BLOCK); other blk_done_i bits ignored.
REQ-026 In REDIR: if blk_req_i[0] = 1, all fields and pc BLOCK, unit_en_o = only bit 0, next state REDIR_WAIT; otherwise behave as RUN (REQ-021/022/024) including next state.
REQ-027 In REDIR_WAIT: all fields and pc BLOCK, unit_en_o = only bit 0; when blk_done_i[0] = 1, field 0 BUBBLE (discard stale fetch), next state REDIR.
REQ-028 stall_cnt_o SHALL increment each cycle the state is STALL or REDIR_WAIT, saturate at 2^CNT_W-1, and clear to 0 on any cycle the state is RUN or REDIR.
REQ-029 wd_o SHALL be 1 whenever stall_cnt_o >= WD_LIMIT, else 0.

Reset
REQ-030 On rst = 1 at a clk edge: state RUN, stall_cnt_o 0, wd_o 0, owner 0.
REQ-031 While rst = 1: all stage fields BUBBLE, pc BLOCK, unit_en_o 0, pc_new_o = redirect_pc_i; reset mid-stall abandons the stall with no further BLOCK cycles.

Configuration
REQ-032 Macro PIPE_STALL_CTRL_TRAP_EN SHALL compile in trap handling.
REQ-033 Defined: trap_i = 1 in any state (rst = 0) overrides all else: pc LOAD, pc_new_o = trap_pc_i, all fields BUBBLE, unit_en_o all ones, next state RUN, counter cleared.
REQ-034 Undefined: trap_i and trap_pc_i remain as ports but are ignored; pc_new_o always equals redirect_pc_i.

Verification
REQ-035 Defaults; blk_req_i = 4'b1000 one cycle, blk_done_i[3] after 5 cycles -> 6 cycles all BLOCK, unit_en_o = 4'b1000, stall_cnt_o reaches 5, then RUN.
REQ-036 blk_req_i = 4'b0101 with redirect_i = 1 -> owner 2, redirect ignored, STALL entered; after done, redirect taken: pc LOAD, stage_ctrl_o = 8'b00_00_10_10.
REQ-037 Redirect to 0x8000_0100, next cycle blk_req_i[0] = 1, blk_done_i[0] 3 cycles later -> REDIR_WAIT, field 0 BUBBLE on done cycle, then REDIR, then RUN.
REQ-038 WD_LIMIT = 4, stall held 10 cycles -> wd_o rises on 4th stall cycle, stays 1, clears on return to RUN; CNT_W = 3 held 12 cycles -> stall_cnt_o saturates at 7.
REQ-039 With PIPE_STALL_CTRL_TRAP_EN, trap_i mid-STALL with trap_pc_i = 0x8000_0000 -> same cycle pc LOAD 0x8000_0000, all fields BUBBLE, next state RUN; without macro -> no effect.
REQ-040 rst asserted during REDIR_WAIT -> next cycle state RUN, counter 0, all fields RUN after rst deasserts.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: freezes the pipe for blocking units, injects redirect bubbles.
// Optional trap flush is compiled in with `define PIPE_STALL_CTRL_TRAP_EN.
module pipe_stall_ctrl #(
  parameter int STAGES   = 4,
  parameter int PC_W     = 64,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 8,
  parameter int WD_LIMIT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STAGES-1:0]     blk_req_i,
  input  logic [STAGES-1:0]     blk_done_i,
  input  logic                  redirect_i,
  input  logic [PC_W-1:0]       redirect_pc_i,
  input  logic                  trap_i,
  input  logic [PC_W-1:0]       trap_pc_i,
  output logic [2*STAGES-1:0]   stage_ctrl_o,
  output logic [1:0]            pc_ctrl_o,
  output logic [PC_W-1:0]       pc_new_o,
  output logic [STAGES-1:0]     unit_en_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic                  wd_o
);

  localparam int OWN_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_STALL      = 2'd1;
  localparam logic [1:0] ST_REDIR      = 2'd2;
  localparam logic [1:0] ST_REDIR_WAIT = 2'd3;

  localparam logic [1:0] F_RUN    = 2'b00;
  localparam logic [1:0] F_BLOCK  = 2'b01;
  localparam logic [1:0] F_BUBBLE = 2'b10;

  localparam logic [1:0] PC_RUN   = 2'b00;
  localparam logic [1:0] PC_BLOCK = 2'b01;
  localparam logic [1:0] PC_LOAD  = 2'b10;

  logic [1:0]        state_reg, state_next;
  logic [OWN_W-1:0]  owner_reg, owner_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [OWN_W-1:0]  req_owner;
  logic              req_any;
  logic [1:0]        field_val [STAGES];
  logic [STAGES-1:0] en_vec;

`ifndef PIPE_STALL_CTRL_TRAP_EN
  logic unused_trap;
  assign unused_trap = ^{trap_i, trap_pc_i};
`endif

  // Highest requesting index wins ownership of the freeze.
  always_comb begin
    req_any   = |blk_req_i;
    req_owner = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (blk_req_i[i]) req_owner = OWN_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    pc_ctrl_o  = PC_RUN;
    pc_new_o   = redirect_pc_i;
    en_vec     = '1;
    for (int i = 0; i < STAGES; i++) field_val[i] = F_RUN;

    if (rst) begin
      for (int i = 0; i < STAGES; i++) field_val[i] = F_BUBBLE;
      pc_ctrl_o  = PC_BLOCK;
      en_vec     = '0;
      state_next = ST_RUN;
      owner_next = '0;
    end
`ifdef PIPE_STALL_CTRL_TRAP_EN
    else if (trap_i) begin
      for (int i = 0; i < STAGES; i++) field_val[i] = F_BUBBLE;
      pc_ctrl_o  = PC_LOAD;
      pc_new_o   = trap_pc_i;
      state_next = ST_RUN;
    end
`endif
    else begin
      case (state_reg)
        ST_STALL: begin
          for (int i = 0; i < STAGES; i++) field_val[i] = F_BLOCK;
          pc_ctrl_o         = PC_BLOCK;
          en_vec            = '0;
          en_vec[owner_reg] = 1'b1;
          if (blk_done_i[owner_reg]) state_next = ST_RUN;
        end
        ST_REDIR_WAIT: begin
          for (int i = 0; i < STAGES; i++) field_val[i] = F_BLOCK;
          pc_ctrl_o = PC_BLOCK;
          en_vec    = '0;
          en_vec[0] = 1'b1;
          // Fetch result belongs to the pre-redirect stream: drop it.
          if (blk_done_i[0]) begin
            field_val[0] = F_BUBBLE;
            state_next   = ST_REDIR;
          end
        end
        default: begin
          if (state_reg == ST_REDIR && blk_req_i[0]) begin
            for (int i = 0; i < STAGES; i++) field_val[i] = F_BLOCK;
            pc_ctrl_o  = PC_BLOCK;
            en_vec     = '0;
            en_vec[0]  = 1'b1;
            state_next = ST_REDIR_WAIT;
          end else if (req_any) begin
            for (int i = 0; i < STAGES; i++) field_val[i] = F_BLOCK;
            pc_ctrl_o         = PC_BLOCK;
            en_vec            = '0;
            en_vec[req_owner] = 1'b1;
            owner_next        = req_owner;
            state_next        = ST_STALL;
          end else if (redirect_i) begin
            for (int i = 0; i < BR_STAGE; i++) field_val[i] = F_BUBBLE;
            pc_ctrl_o  = PC_LOAD;
            state_next = ST_REDIR;
          end else begin
            state_next = ST_RUN;
          end
        end
      endcase
    end
  end

  // Counter holds the number of stall cycles including the one being presented.
  always_comb begin
    cnt_next = '0;
    if (state_next == ST_STALL || state_next == ST_REDIR_WAIT) begin
      cnt_next = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      owner_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_field
    assign stage_ctrl_o[2*gi +: 2] = field_val[gi];
  end

  assign unit_en_o   = en_vec;
  assign stall_cnt_o = cnt_reg;
  assign wd_o        = (cnt_reg >= CNT_W'(WD_LIMIT));

endmodule
